// File: rtl/decode_writeback.sv
// Y86-64 decode and write-back stage: field decode, 15-entry register file, two read ports plus a debug port.
// Optional write-through forwarding of the in-flight valE/valM is enabled by defining DECODE_FWD_EN.
module decode_writeback #(
    parameter logic [63:0] RSP_INIT = 64'd0,
    parameter int          NREG     = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  icode,
    input  logic [3:0]  ra,
    input  logic [3:0]  rb,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [63:0] valA,
    output logic [63:0] valB,
    input  logic [3:0]  dbg_addr,
    output logic [63:0] dbg_data
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RRSP  = 4'h4;

    logic [63:0] regs_q [NREG];

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            4'h2: begin srcA = ra; dstE = cnd ? rb : RNONE; end
            4'h3: begin dstE = rb; end
            4'h4: begin srcA = ra; srcB = rb; end
            4'h5: begin srcB = rb; dstM = ra; end
            4'h6: begin srcA = ra; srcB = rb; dstE = rb; end
            4'h8: begin srcB = RRSP; dstE = RRSP; end
            4'h9: begin srcA = RRSP; srcB = RRSP; dstE = RRSP; end
            4'hA: begin srcA = ra; srcB = RRSP; dstE = RRSP; end
            4'hB: begin srcA = RRSP; srcB = RRSP; dstE = RRSP; dstM = ra; end
            default: ;
        endcase
    end

    // Stored value for an ID, optionally overridden by the value being committed this cycle (M over E).
    function automatic logic [63:0] rd_port(input logic [3:0] id, input logic [63:0] stored,
                                            input logic we, input logic [3:0] de, input logic [3:0] dm,
                                            input logic [63:0] ve, input logic [63:0] vm);
        logic [63:0] v;
        v = (id == RNONE) ? 64'd0 : stored;
`ifdef DECODE_FWD_EN
        if (we && id != RNONE) begin
            if (id == dm)      v = vm;
            else if (id == de) v = ve;
        end
`endif
        return v;
    endfunction

    logic [63:0] stored_a, stored_b, stored_dbg;

    always_comb begin
        stored_a   = (int'(srcA) < NREG) ? regs_q[srcA] : 64'd0;
        stored_b   = (int'(srcB) < NREG) ? regs_q[srcB] : 64'd0;
        stored_dbg = (int'(dbg_addr) < NREG) ? regs_q[dbg_addr] : 64'd0;
        valA       = rd_port(srcA, stored_a, wb_en, dstE, dstM, valE, valM);
        valB       = rd_port(srcB, stored_b, wb_en, dstE, dstM, valE, valM);
        dbg_data   = rd_port(dbg_addr, stored_dbg, wb_en, dstE, dstM, valE, valM);
    end

    // The M-port write is issued last so it wins when both ports target the same register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= (i == int'(RRSP)) ? RSP_INIT : 64'd0;
        end else if (wb_en) begin
            if (dstE != RNONE) regs_q[dstE] <= valE;
            if (dstM != RNONE) regs_q[dstM] <= valM;
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Randomized and directed bench for decode_writeback against a table-driven register-file model.
module tb_decode_writeback;

    localparam logic [63:0] RSP = 64'h100;

    logic        clk = 1'b0;
    logic        reset, cnd, wb_en;
    logic [3:0]  icode, ra, rb, dbg_addr;
    logic [63:0] valE, valM;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] valA, valB, dbg_data;

    int nvec = 0;
    int nerr = 0;

    logic [63:0] m [15];

    decode_writeback #(.RSP_INIT(RSP), .NREG(15)) dut (
        .clk(clk), .reset(reset), .icode(icode), .ra(ra), .rb(rb), .cnd(cnd),
        .valE(valE), .valM(valM), .wb_en(wb_en),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
        .valA(valA), .valB(valB), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mread(input logic [3:0] id, input logic w,
                                          input logic [3:0] de, input logic [3:0] dm,
                                          input logic [63:0] e, input logic [63:0] mm);
        logic [63:0] v;
        v = (id == 4'hF) ? 64'd0 : m[id];
`ifdef DECODE_FWD_EN
        if (w && id != 4'hF) begin
            if (id == dm)      v = mm;
            else if (id == de) v = e;
        end
`endif
        return v;
    endfunction

    // xsel: 0 = no extra check, 1 = dbg_data must equal xv, 2 = valB must equal xv
    task automatic step(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b, input logic c,
                        input logic [63:0] e, input logic [63:0] mm, input logic w, input logic r,
                        input logic [3:0] d, input int xsel, input logic [63:0] xv);
        logic [3:0] esa, esb, ede, edm;
        icode = ic; ra = a; rb = b; cnd = c; valE = e; valM = mm;
        wb_en = w; reset = r; dbg_addr = d;
        #1;
        esa = (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) ? a : (ic inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
        esb = (ic inside {4'h4, 4'h5, 4'h6}) ? b : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        ede = ((ic == 4'h2 && c) || ic inside {4'h3, 4'h6}) ? b
              : (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
        edm = (ic inside {4'h5, 4'hB}) ? a : 4'hF;
        chk("srcA", {60'd0, srcA}, {60'd0, esa});
        chk("srcB", {60'd0, srcB}, {60'd0, esb});
        chk("dstE", {60'd0, dstE}, {60'd0, ede});
        chk("dstM", {60'd0, dstM}, {60'd0, edm});
        chk("valA", valA, mread(esa, w, ede, edm, e, mm));
        chk("valB", valB, mread(esb, w, ede, edm, e, mm));
        chk("dbg_data", dbg_data, mread(d, w, ede, edm, e, mm));
        if (xsel == 1) chk("dbg_directed", dbg_data, xv);
        if (xsel == 2) chk("valB_directed", valB, xv);
        @(posedge clk);
        if (r) begin
            for (int i = 0; i < 15; i++) m[i] = (i == 4) ? RSP : 64'd0;
        end else if (w) begin
            if (ede != 4'hF) m[ede] = e;
            if (edm != 4'hF) m[edm] = mm;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] fwd_exp;
        step(4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 1, 4'hF, 0, 0);
        for (int a = 0; a < 16; a++)
            step(4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 4'(a), 1, (a == 4) ? RSP : 64'd0);

        step(4'h3, 4'hF, 4'h3, 0, 64'd6, 0, 1, 0, 4'hF, 0, 0);
        step(4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 4'h3, 1, 64'd6);
        step(4'h6, 4'h3, 4'h3, 0, 0, 0, 0, 0, 4'hF, 2, 64'd6);

        step(4'h2, 4'h1, 4'h2, 0, 64'd9, 0, 1, 0, 4'hF, 0, 0);
        step(4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 4'h2, 1, 64'd0);
        step(4'h2, 4'h1, 4'h2, 1, 64'd9, 0, 1, 0, 4'hF, 0, 0);
        step(4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 4'h2, 1, 64'd9);

        step(4'hB, 4'h4, 4'hF, 0, 64'h108, 64'hABCD, 1, 0, 4'hF, 0, 0);
        step(4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 4'h4, 1, 64'hABCD);

        step(4'h3, 4'hF, 4'h5, 0, 64'd7, 0, 0, 0, 4'hF, 0, 0);
        step(4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 4'h5, 1, 64'd0);
        step(4'h3, 4'hF, 4'h5, 0, 64'd7, 0, 1, 1, 4'hF, 0, 0);
        step(4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 4'h5, 1, 64'd0);
        step(4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 4'h4, 1, RSP);

        step(4'h3, 4'hF, 4'h3, 0, 64'h11, 0, 1, 0, 4'hF, 0, 0);
`ifdef DECODE_FWD_EN
        fwd_exp = 64'h55;
`else
        fwd_exp = 64'h11;
`endif
        step(4'h6, 4'hF, 4'h3, 0, 64'h55, 0, 1, 0, 4'hF, 2, fwd_exp);
        step(4'h1, 4'hF, 4'hF, 0, 0, 0, 0, 0, 4'h3, 1, 64'h55);

        for (int n = 0; n < 300; n++)
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 3),
                 4'($urandom_range(0, 15)), 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
